// File: rtl/prbs_pkg.sv
// prbs_pkg: shared encodings for the PRBS checker and its matching generator.
// Holds polynomial selects, tap positions, checker states and history length.
package prbs_pkg;

    // Longest supported polynomial is PRBS31, so 31 bits of history suffice.
    localparam int HIST_LEN = 31;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS23 = 2'd2,
        MODE_PRBS31 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    // Taps stored as hist indices: a delay of D is hist[D-1].
    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
    } taps_t;

    localparam taps_t TAPS_PRBS7  = '{a: 5'd6,  b: 5'd5};
    localparam taps_t TAPS_PRBS15 = '{a: 5'd14, b: 5'd13};
    localparam taps_t TAPS_PRBS23 = '{a: 5'd22, b: 5'd17};
    localparam taps_t TAPS_PRBS31 = '{a: 5'd30, b: 5'd27};

    function automatic taps_t mode_taps(input logic [1:0] m);
        taps_t t;
        case (mode_e'(m))
            MODE_PRBS7:  t = TAPS_PRBS7;
            MODE_PRBS15: t = TAPS_PRBS15;
            MODE_PRBS23: t = TAPS_PRBS23;
            MODE_PRBS31: t = TAPS_PRBS31;
            default:     t = TAPS_PRBS31;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/prbs_nextword.sv
// prbs_nextword: runs DATABIT serial steps of the selected PRBS recurrence.
// Ports: hist (last 31 bits, [0] newest), mode -> pred (MSB earliest), hist_nxt.
module prbs_nextword
    import prbs_pkg::*;
#(
    parameter int DATABIT = 32
) (
    input  logic [HIST_LEN-1:0] hist,
    input  logic [1:0]          mode,
    output logic [DATABIT-1:0]  pred,
    output logic [HIST_LEN-1:0] hist_nxt
);

    taps_t               taps;
    logic [HIST_LEN-1:0] h;
    logic                b;

    always_comb begin
        taps = mode_taps(mode);
        h    = hist;
        b    = 1'b0;
        pred = '0;
        // MSB of the word is the earliest bit, so fill from the top down.
        for (int i = DATABIT - 1; i >= 0; i--) begin
            b       = h[taps.a] ^ h[taps.b];
            pred[i] = b;
            h       = {h[HIST_LEN-2:0], b};
        end
        hist_nxt = h;
    end

endmodule

// File: rtl/prbs_mon_sync.sv
// prbs_mon_sync: self-synchronising PRBS7/15/23/31 checker with lock tracking,
// saturating bit-error count and per-word parity check.
// Ports: clk, rst_ (async low), idat/ival/ipar (received word), mode (poly),
//        clr (clear errcnt) -> lock, errprbs, errpar (pulses), errcnt.
module prbs_mon_sync
    import prbs_pkg::*;
#(
    parameter int DATABIT  = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int CNTBIT   = 32,
    parameter int PAR_ODD  = 0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [DATABIT-1:0] idat,
    input  logic               ival,
    input  logic               ipar,
    input  logic [1:0]         mode,
    input  logic               clr,
    output logic               lock,
    output logic               errprbs,
    output logic               errpar,
    output logic [CNTBIT-1:0]  errcnt
);

    localparam int PW = $clog2(DATABIT + 1);
    localparam int SW = ((CNTBIT > PW) ? CNTBIT : PW) + 1;
    localparam logic [3:0] GOOD_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] BAD_LAST  = 4'(LOSS_CNT - 1);
    localparam logic PAR_SENSE = (PAR_ODD != 0);

    // Stage 1: registered input word.
    logic [DATABIT-1:0]  s1_dat;
    logic                s1_val;
    logic                s1_par;

    // Checker state.
    logic [1:0]          mode_q;
    state_e              state_q, state_d;
    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic [3:0]          good_q, good_d;
    logic [3:0]          bad_q, bad_d;

    // Stage 2: comparison results awaiting report.
    logic [DATABIT-1:0]  s2_err;
    logic                s2_chk;
    logic                s2_perr;

    logic [DATABIT-1:0]  pred;
    logic [HIST_LEN-1:0] hist_adv;
    logic [DATABIT-1:0]  err_vec;
    logic                mism;
    logic                mode_chg;
    logic                chk;
    logic                par_bad;
    logic [PW-1:0]       pop;
    logic [SW-1:0]       sum;

    prbs_nextword #(
        .DATABIT (DATABIT)
    ) u_next (
        .hist     (hist_q),
        .mode     (mode_q),
        .pred     (pred),
        .hist_nxt (hist_adv)
    );

    assign err_vec  = s1_dat ^ pred;
    assign mism     = |err_vec;
    assign mode_chg = (mode != mode_q);
    assign par_bad  = s1_val & ((^s1_dat ^ PAR_SENSE) != s1_par);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_dat <= '0;
            s1_val <= 1'b0;
            s1_par <= 1'b0;
            mode_q <= 2'd0;
        end else begin
            s1_val <= ival;
            mode_q <= mode;
            if (ival) begin
                s1_dat <= idat;
                s1_par <= ipar;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        good_d  = good_q;
        bad_d   = bad_q;
        chk     = 1'b0;
        if (mode_chg) begin
            // Drops the word being compared; it belongs to the old polynomial.
            state_d = ST_SEARCH;
            good_d  = 4'd0;
            bad_d   = 4'd0;
        end else if (s1_val) begin
            unique case (state_q)
                ST_SEARCH: begin
                    hist_d  = s1_dat[HIST_LEN-1:0];
                    state_d = ST_VERIFY;
                    good_d  = 4'd0;
                end
                ST_VERIFY: begin
                    if (mism) begin
                        // Back to search, which seeds from this same word.
                        hist_d  = s1_dat[HIST_LEN-1:0];
                        state_d = ST_VERIFY;
                        good_d  = 4'd0;
                    end else begin
                        hist_d = hist_adv;
                        if (good_q == GOOD_LAST) begin
                            state_d = ST_LOCK;
                            good_d  = 4'd0;
                            bad_d   = 4'd0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    chk    = 1'b1;
                    // Free-running reference: errors never enter hist.
                    hist_d = hist_adv;
                    if (mism) begin
                        if (bad_q == BAD_LAST) begin
                            state_d = ST_SEARCH;
                            bad_d   = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else begin
                        bad_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_SEARCH;
            hist_q  <= '0;
            good_q  <= 4'd0;
            bad_q   <= 4'd0;
            lock    <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            lock    <= (state_d == ST_LOCK);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s2_err  <= '0;
            s2_chk  <= 1'b0;
            s2_perr <= 1'b0;
        end else begin
            s2_err  <= err_vec;
            s2_chk  <= chk;
            s2_perr <= par_bad;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATABIT; i++) begin
            pop = pop + PW'(s2_err[i]);
        end
    end

    assign sum = SW'(errcnt) + SW'(pop);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            errprbs <= 1'b0;
            errpar  <= 1'b0;
            errcnt  <= '0;
        end else begin
            errprbs <= s2_chk & (|s2_err);
            errpar  <= s2_perr;
            if (clr) begin
                errcnt <= '0;
            end else if (s2_chk) begin
                // Any carry past CNTBIT means the count has saturated.
                if (|sum[SW-1:CNTBIT]) begin
                    errcnt <= '1;
                end else begin
                    errcnt <= sum[CNTBIT-1:0];
                end
            end
        end
    end

endmodule
